fsk_frame_rx: RTL and testbench

FSK_FRAME_RX -- requirements
Module: fsk_frame_rx

---
 rtl/fsk_pkg.sv | 20 ++
 rtl/fsk_bit_vote.sv | 59 +++++
 rtl/fsk_frame_rx.sv | 142 ++++++++++++++
 tb/tb_fsk_frame_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// fsk_pkg -- shared definitions for the FSK frame receiver.
//   state_t          receiver FSM states
//   DEF_BIT_CYCLES   default clk cycles per bit (50 kbit/s at 50 MHz)
//   DEF_DATA_BITS    default payload bits per frame
//   IDLE_LEVEL       line level while no frame is on the wire
package fsk_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   localparam int   DEF_BIT_CYCLES = 1000;
   localparam int   DEF_DATA_BITS  = 8;
   localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/fsk_bit_vote.sv
// fsk_bit_vote -- input synchronizer and 3-sample majority bit decision.
//   clk, rst    system clock, synchronous active-high reset
//   data_in     asynchronous demodulated line (idle high)
//   cnt         current bit-counter value from the frame FSM
//   sync        synchronized line level
//   fall        synchronized 1->0 transition seen this cycle
//   vote        majority of samples at cnt = mid-1, mid, mid+1
//   vote_done   high in the cycle the third sample is taken (vote valid)
module fsk_bit_vote
   import fsk_pkg::*;
#(
   parameter int BIT_CYCLES = DEF_BIT_CYCLES,
   parameter int CW         = $clog2(BIT_CYCLES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          data_in,
   input  logic [CW-1:0] cnt,
   output logic          sync,
   output logic          fall,
   output logic          vote,
   output logic          vote_done
);

   localparam logic [CW-1:0] SAMPLE_0 = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] SAMPLE_1 = CW'(BIT_CYCLES / 2);
   localparam logic [CW-1:0] SAMPLE_2 = CW'(BIT_CYCLES / 2 + 1);

   logic meta;
   logic sync_d;
   logic s0;
   logic s1;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge value of its neighbour; with blocking '=' the
   // two synchronizer stages would collapse into a single flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= IDLE_LEVEL;
         sync   <= IDLE_LEVEL;
         sync_d <= IDLE_LEVEL;
         s0     <= IDLE_LEVEL;
         s1     <= IDLE_LEVEL;
      end else begin
         meta   <= data_in;
         sync   <= meta;
         sync_d <= sync;
         if (cnt == SAMPLE_0) s0 <= sync;
         if (cnt == SAMPLE_1) s1 <= sync;
      end
   end

   // Third sample is the live synchronized level, so the decision is ready
   // in the same cycle it is taken.
   assign vote      = (s0 & s1) | (s0 & sync) | (s1 & sync);
   assign vote_done = (cnt == SAMPLE_2);
   assign fall      = sync_d & ~sync;

endmodule

// File: rtl/fsk_frame_rx.sv
// fsk_frame_rx -- asynchronous-frame receiver for the FSK modem bit stream.
// Frame: start 0, DATA_BITS payload bits LSB first, stop 1.
//   clk, rst    system clock, synchronous active-high reset
//   enable      receiver enable; low aborts any frame in progress
//   data_in     asynchronous demodulated line (idle high)
//   rx_data     received byte, valid while rx_valid is high
//   rx_valid    rx_data holds an unconsumed byte
//   rx_ready    consumer accepts rx_data (transfer on rx_valid && rx_ready)
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good byte dropped because buffer was full
module fsk_frame_rx
   import fsk_pkg::*;
#(
   parameter int BIT_CYCLES = DEF_BIT_CYCLES,
   parameter int DATA_BITS  = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 data_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;

   logic sync;
   logic fall;
   logic vote;
   logic vote_done;
   logic good_stop;
   logic load;

   fsk_bit_vote #(
      .BIT_CYCLES (BIT_CYCLES),
      .CW         (CW)
   ) u_vote (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .cnt       (cnt),
      .sync      (sync),
      .fall      (fall),
      .vote      (vote),
      .vote_done (vote_done)
   );

   assign good_stop = enable && (state == STOP) && vote_done && vote;
   // A byte lands only if the buffer is empty or being drained this cycle.
   assign load      = good_stop && (!rx_valid || rx_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // Output buffer runs regardless of enable.
         if (load) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (good_stop && rx_valid && !rx_ready) overrun <= 1'b1;

         if (!enable) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
         end else begin
            // Free-running bit timer while a frame is in progress; its wrap
            // is the bit boundary, so START->DATA needs no explicit restart.
            if (state == START || state == DATA || state == STOP)
               cnt <= (cnt == CW'(BIT_CYCLES - 1)) ? '0 : cnt + 1'b1;
            else
               cnt <= '0;

            case (state)
               IDLE: begin
                  if (fall) begin
                     state <= START;
                     cnt   <= '0;
                  end
               end
               START: begin
                  if (vote_done) begin
                     if (!vote) begin
                        state   <= DATA;
                        bit_idx <= '0;
                     end else begin
                        state   <= IDLE;
                     end
                  end
               end
               DATA: begin
                  if (vote_done) begin
                     shreg <= (shreg >> 1) | (DATA_BITS'(vote) << (DATA_BITS - 1));
                     if (bit_idx == IW'(DATA_BITS - 1)) state <= STOP;
                     else bit_idx <= bit_idx + 1'b1;
                  end
               end
               STOP: begin
                  // Leave right after the vote so a start edge in the second
                  // half of the stop bit is already caught by IDLE.
                  if (vote_done) begin
                     if (vote) begin
                        state     <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_IDLE;
                     end
                  end
               end
               WAIT_IDLE: begin
                  // A held-low break must not look like a new start edge.
                  if (sync) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fsk_frame_rx.sv
// tb_fsk_frame_rx -- directed bench for fsk_frame_rx.
module tb_fsk_frame_rx;

   localparam int BC = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       data_in;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   fsk_frame_rx #(.BIT_CYCLES(BC), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .data_in   (data_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Activity monitor, sampled on the falling edge.
   int         cyc = 0;
   int         n_xfer = 0;
   int         n_fe = 0;
   int         n_ov = 0;
   int         n_vcyc = 0;
   int         last_rise = 0;
   logic       valid_q = 1'b0;
   logic [7:0] got [0:63];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) begin
         got[n_xfer[5:0]] = rx_data;
         n_xfer = n_xfer + 1;
      end
      if (frame_err) n_fe = n_fe + 1;
      if (overrun) n_ov = n_ov + 1;
      if (rx_valid) n_vcyc = n_vcyc + 1;
      if (rx_valid && !valid_q) last_rise = cyc;
      valid_q = rx_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   int t_start;

   task automatic send_bit(input logic b);
      data_in = b;
      repeat (BC) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      t_start = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   int x0, fe0, ov0, v0, lat;

   task automatic snap();
      x0  = n_xfer;
      fe0 = n_fe;
      ov0 = n_ov;
      v0  = n_vcyc;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; rx_ready = 1'b1; data_in = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      repeat (BC) @(negedge clk);

      // Frame 0xA5, consumer always ready.
      snap();
      send_frame(8'hA5, 1'b1);
      repeat (BC) @(negedge clk);
      lat = last_rise - t_start;
      check("a5_xfer_count", n_xfer - x0, 1);
      check("a5_data", got[x0[5:0]], 8'hA5);
      check("a5_latency_window", (lat >= BC * 19 / 2) && (lat <= BC * 19 / 2 + 10), 1);
      check("a5_valid_width", n_vcyc - v0, 1);
      check("a5_frame_err", n_fe - fe0, 0);
      check("a5_overrun", n_ov - ov0, 0);

      // 200 ns low glitch on idle line.
      snap();
      data_in = 1'b0;
      repeat (10) @(negedge clk);
      data_in = 1'b1;
      repeat (2 * BC) @(negedge clk);
      check("glitch_xfer", n_xfer - x0, 0);
      check("glitch_valid", n_vcyc - v0, 0);
      check("glitch_frame_err", n_fe - fe0, 0);
      check("glitch_overrun", n_ov - ov0, 0);

      // 0x3C with bad stop, break held 3 more bits, then long idle.
      snap();
      send_frame(8'h3C, 1'b0);
      repeat (3) send_bit(1'b0);
      repeat (11) send_bit(1'b1);
      check("brk_frame_err", n_fe - fe0, 1);
      check("brk_xfer", n_xfer - x0, 0);
      check("brk_valid", n_vcyc - v0, 0);
      check("brk_overrun", n_ov - ov0, 0);

      // 0x11 then 0x22 back to back with consumer stalled.
      rx_ready = 1'b0;
      snap();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_bit(1'b1);
      check("ovr_overrun", n_ov - ov0, 1);
      check("ovr_valid_held", rx_valid, 1);
      check("ovr_data_held", rx_data, 8'h11);
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("ovr_xfer_count", n_xfer - x0, 1);
      check("ovr_xfer_data", got[x0[5:0]], 8'h11);
      check("ovr_valid_clear", rx_valid, 0);

      // Reset in the middle of 0x55's data bits, then 0x0F.
      snap();
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      data_in = 1'b1;
      check("rst_mid_valid", rx_valid, 0);
      repeat (2 * BC) @(negedge clk);
      send_frame(8'h0F, 1'b1);
      repeat (BC) @(negedge clk);
      check("rst_mid_xfer_count", n_xfer - x0, 1);
      check("rst_mid_data", got[x0[5:0]], 8'h0F);
      check("rst_mid_frame_err", n_fe - fe0, 0);

      // Enable dropped during 0x77, restored, then 0x81.
      snap();
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      enable = 1'b0;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1);
      enable = 1'b1;
      repeat (BC) @(negedge clk);
      send_frame(8'h81, 1'b1);
      repeat (BC) @(negedge clk);
      check("en_xfer_count", n_xfer - x0, 1);
      check("en_data", got[x0[5:0]], 8'h81);
      check("en_frame_err", n_fe - fe0, 0);
      check("en_overrun", n_ov - ov0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
